col_conf_loader: RTL and testbench
==================================

// Module: col_conf_loader
// PURPOSE
//  Configuration/constant loader sitting directly upstream of one PE column.
//  - Accepts a serial stream of config words over a valid/ready handshake and fills per-PE shadow registers.
//  - Atomically commits the shadow contents to the CONF_*/CONST outputs on COMMIT, so the column never sees a half-written context.
//  - Outputs connect 1:1 to the column's CONF_ALU/SEL_A/SEL_B/SE and IN_CONST_A/B buses.
// PARAMETERS
//  PE_NUM  8   PEs per column; slice i feeds PE_i (i=0 is the south-most PE)
//  DATA_W  16  datapath and config-word width
//  ALU_W   4   per-PE ALU opcode width
//  SEL_W   4   per-PE operand-select width (A and B each)
//  SE_W    2   per-PE SE-control width; ALU_W+2*SEL_W+SE_W <= DATA_W
// PORTS
//  CLK         in   1               clock
//  RST_N       in   1               async active-low reset
//  CFG_VALID   in   1               config word valid
//  CFG_READY   out  1               loader accepts word this cycle
//  CFG_SOF     in   1               word is first of frame (qualified by CFG_VALID)
//  CFG_DATA    in   DATA_W          config word
//  CFG_PAR     in   1               even parity of CFG_DATA (only with COL_CONF_PARITY_EN)
//  COMMIT      in   1               pulse: copy shadow to active
//  ABORT       in   1               pulse: drop partial frame
//  CONF_ALU    out  PE_NUM*ALU_W    active ALU opcodes, PE i at [i*ALU_W +: ALU_W]
//  CONF_SEL_A  out  PE_NUM*SEL_W    active operand-A selects
//  CONF_SEL_B  out  PE_NUM*SEL_W    active operand-B selects
//  CONF_SE     out  PE_NUM*SE_W     active SE controls
//  CONST_A     out  PE_NUM*DATA_W   active constant A per PE
//  CONST_B     out  PE_NUM*DATA_W   active constant B per PE
//  ARMED       out  1               full frame in shadow, awaiting COMMIT
//  DONE        out  1               one-cycle pulse the cycle after commit
//  CFG_ERR     out  1               sticky protocol/parity error
// BEHAVIOUR
//  - Reset: all active and shadow regs 0 (NOP context); CFG_READY=0 for the reset cycle, then 1; ARMED=0, DONE=0, CFG_ERR=0; FSM=IDLE.
//  - Frame: 3*PE_NUM words (24 at default). Word 3i = packed conf for PE i: [ALU_W-1:0]=ALU, then SEL_A, SEL_B, SE upward; unused MSBs ignored.
//  - Word 3i+1 = CONST_A of PE i; word 3i+2 = CONST_B of PE i.
//  - Handshake: word accepted when CFG_VALID&&CFG_READY at rising CLK; written to shadow on that edge. No combinational VALID->READY path.
//  - FSM IDLE: READY=1; non-SOF words dropped, CFG_ERR set; SOF word -> written as word 0, cnt=1, go LOAD.
//  - FSM LOAD: READY=1; each accepted word increments cnt; word at cnt=3*PE_NUM-1 -> ARMED.
//  - FSM LOAD: SOF mid-frame restarts the frame (SOF word becomes word 0), CFG_ERR set.
//  - FSM ARMED: READY=0, ARMED=1. COMMIT -> active<=shadow on same edge, DONE=1 next cycle, go IDLE.
//  - COMMIT in IDLE/LOAD ignored, no error. ABORT in LOAD/ARMED -> IDLE; shadow content undefined-but-unused, active untouched.
//  - COMMIT and ABORT in the same cycle: ABORT wins.
//  - Latency: COMMIT edge to new CONF_* visible = 1 cycle (registered outputs). Active outputs only change on commit or reset.
//  - CFG_ERR clears only on acceptance of a SOF word in IDLE or on reset.
//  - Async reset mid-frame: all state cleared, partial frame lost, outputs back to NOP immediately.
// CONFIGURATION
//  - COL_CONF_PARITY_EN defined: CFG_PAR port exists; accepted word with ^{CFG_DATA,CFG_PAR}!=0 is not written; CFG_ERR set; FSM -> IDLE; active untouched.
//  - COL_CONF_PARITY_EN undefined: no CFG_PAR port, no check.
// STRUCTURE
//  - SMA.h gains: per-PE widths (ALU/SEL/SE), frame length 3*PE_NUM, FSM state encodings, conf-word field offsets.
//  - Sub-module col_conf_slot: one PE's shadow+active regs (conf, const A, const B) with write-enable per word type and commit strobe.
//  - col_conf_slot is instantiated PE_NUM times; top holds FSM, counter, decode.
// TESTING
//  - Reset: RST_N low mid-run -> all CONF_*/CONST=0, READY=1 one cycle after release, ARMED=0.
//  - Full frame: 24 words, PE i conf=i*16+1, CONST_A=0x100+i, CONST_B=0x200+i.
//    Outputs unchanged until COMMIT; one cycle after COMMIT, CONF_ALU[3:0]=1 and CONST_B slice 7=0x207; DONE pulses once.
//  - Backpressure: VALID held with gaps and held through ARMED -> READY=0 in ARMED; exactly 24 words accepted.
//  - SOF at word 10 -> frame restarts; CFG_ERR=1; 24 further words then COMMIT loads only the new frame.
//  - ABORT at word 5 then COMMIT -> outputs keep the previous context; FSM IDLE.
//  - COMMIT+ABORT same cycle in ARMED -> no update.
//  - COL_CONF_PARITY_EN: bad parity on word 7 -> CFG_ERR=1, IDLE, active unchanged.

Source files
------------

// File: rtl/col_conf_loader_pkg.sv
// Shared widths, frame geometry and encodings for the column configuration loader.
// Optional even-parity checking on config words is enabled with COL_CONF_PARITY_EN.
package col_conf_loader_pkg;

  localparam int PE_NUM    = 8;
  localparam int DATA_W    = 16;
  localparam int ALU_W     = 4;
  localparam int SEL_W     = 4;
  localparam int SE_W      = 2;
  localparam int CONF_W    = ALU_W + 2*SEL_W + SE_W;
  localparam int FRAME_LEN = 3*PE_NUM;
  localparam int PE_IDX_W  = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;

  // Field offsets inside a packed conf word, LSB first.
  localparam int ALU_OFS   = 0;
  localparam int SEL_A_OFS = ALU_W;
  localparam int SEL_B_OFS = ALU_W + SEL_W;
  localparam int SE_OFS    = ALU_W + 2*SEL_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ARMED = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    WORD_CONF    = 2'd0,
    WORD_CONST_A = 2'd1,
    WORD_CONST_B = 2'd2
  } word_e;

endpackage

// File: rtl/col_conf_slot.sv
// One PE's shadow and active configuration registers; shadow is written word by
// word, active is refreshed from shadow only on the commit strobe.
module col_conf_slot
  import col_conf_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_conf,
  input  logic              wr_const_a,
  input  logic              wr_const_b,
  input  logic              commit,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ALU_W-1:0]  alu,
  output logic [SEL_W-1:0]  sel_a,
  output logic [SEL_W-1:0]  sel_b,
  output logic [SE_W-1:0]   se,
  output logic [DATA_W-1:0] const_a,
  output logic [DATA_W-1:0] const_b
);

  logic [CONF_W-1:0] shadow_conf;
  logic [DATA_W-1:0] shadow_a;
  logic [DATA_W-1:0] shadow_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_conf <= '0;
      shadow_a    <= '0;
      shadow_b    <= '0;
    end else begin
      if (wr_conf)    shadow_conf <= wr_data[CONF_W-1:0];
      if (wr_const_a) shadow_a    <= wr_data;
      if (wr_const_b) shadow_b    <= wr_data;
    end
  end

  // Active side only moves on commit so the PE never sees a partial context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu     <= '0;
      sel_a   <= '0;
      sel_b   <= '0;
      se      <= '0;
      const_a <= '0;
      const_b <= '0;
    end else if (commit) begin
      alu     <= shadow_conf[ALU_OFS +: ALU_W];
      sel_a   <= shadow_conf[SEL_A_OFS +: SEL_W];
      sel_b   <= shadow_conf[SEL_B_OFS +: SEL_W];
      se      <= shadow_conf[SE_OFS +: SE_W];
      const_a <= shadow_a;
      const_b <= shadow_b;
    end
  end

endmodule

// File: rtl/col_conf_loader.sv
// Serial config loader for one PE column: fills per-PE shadow regs from a framed
// word stream and commits them atomically. Parity check enabled by COL_CONF_PARITY_EN.
module col_conf_loader
  import col_conf_loader_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic                     cfg_sof,
  input  logic [DATA_W-1:0]        cfg_data,
`ifdef COL_CONF_PARITY_EN
  input  logic                     cfg_par,
`endif
  input  logic                     commit,
  input  logic                     abort,
  output logic [PE_NUM*ALU_W-1:0]  conf_alu,
  output logic [PE_NUM*SEL_W-1:0]  conf_sel_a,
  output logic [PE_NUM*SEL_W-1:0]  conf_sel_b,
  output logic [PE_NUM*SE_W-1:0]   conf_se,
  output logic [PE_NUM*DATA_W-1:0] const_a,
  output logic [PE_NUM*DATA_W-1:0] const_b,
  output logic                     armed,
  output logic                     done,
  output logic                     cfg_err
);

  state_e              state;
  logic [PE_IDX_W-1:0] pe_idx;
  word_e               word_sel;

  logic                accept;
  logic                par_ok;
  logic                last_word;
  logic                commit_fire;
  logic                wr_word;
  logic [PE_IDX_W-1:0] wr_pe;
  word_e               wr_type;

  assign accept      = cfg_valid && cfg_ready;
  assign last_word   = (pe_idx == PE_IDX_W'(PE_NUM-1)) && (word_sel == WORD_CONST_B);
  assign commit_fire = (state == ST_ARMED) && commit && !abort;

`ifdef COL_CONF_PARITY_EN
  assign par_ok = ~^{cfg_data, cfg_par};
`else
  assign par_ok = 1'b1;
`endif

  // Shadow write decode; pe_idx/word_sel always point at the next word expected.
  always_comb begin
    wr_word = 1'b0;
    wr_pe   = '0;
    wr_type = WORD_CONF;
    if (accept && par_ok) begin
      if (cfg_sof && (state == ST_IDLE || (state == ST_LOAD && !abort))) begin
        wr_word = 1'b1;
      end else if (state == ST_LOAD && !abort) begin
        wr_word = 1'b1;
        wr_pe   = pe_idx;
        wr_type = word_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pe_idx    <= '0;
      word_sel  <= WORD_CONF;
      cfg_ready <= 1'b0;
      armed     <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      done <= commit_fire;
      case (state)
        ST_IDLE: begin
          cfg_ready <= 1'b1;
          if (accept) begin
            if (!par_ok) begin
              cfg_err <= 1'b1;
            end else if (cfg_sof) begin
              cfg_err  <= 1'b0;
              pe_idx   <= '0;
              word_sel <= WORD_CONST_A;
              state    <= ST_LOAD;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          cfg_ready <= 1'b1;
          if (abort) begin
            state <= ST_IDLE;
          end else if (accept) begin
            if (!par_ok) begin
              cfg_err <= 1'b1;
              state   <= ST_IDLE;
            end else if (cfg_sof) begin
              cfg_err  <= 1'b1;
              pe_idx   <= '0;
              word_sel <= WORD_CONST_A;
            end else if (last_word) begin
              state     <= ST_ARMED;
              armed     <= 1'b1;
              cfg_ready <= 1'b0;
            end else begin
              case (word_sel)
                WORD_CONF:    word_sel <= WORD_CONST_A;
                WORD_CONST_A: word_sel <= WORD_CONST_B;
                default: begin
                  word_sel <= WORD_CONF;
                  pe_idx   <= pe_idx + PE_IDX_W'(1);
                end
              endcase
            end
          end
        end
        ST_ARMED: begin
          if (abort || commit) begin
            state     <= ST_IDLE;
            armed     <= 1'b0;
            cfg_ready <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar i = 0; i < PE_NUM; i++) begin : g_slot
    col_conf_slot u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_conf    (wr_word && wr_pe == PE_IDX_W'(i) && wr_type == WORD_CONF),
      .wr_const_a (wr_word && wr_pe == PE_IDX_W'(i) && wr_type == WORD_CONST_A),
      .wr_const_b (wr_word && wr_pe == PE_IDX_W'(i) && wr_type == WORD_CONST_B),
      .commit     (commit_fire),
      .wr_data    (cfg_data),
      .alu        (conf_alu[i*ALU_W +: ALU_W]),
      .sel_a      (conf_sel_a[i*SEL_W +: SEL_W]),
      .sel_b      (conf_sel_b[i*SEL_W +: SEL_W]),
      .se         (conf_se[i*SE_W +: SE_W]),
      .const_a    (const_a[i*DATA_W +: DATA_W]),
      .const_b    (const_b[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_col_conf_loader.sv
// Scoreboard bench for col_conf_loader: expected contexts are queued at commit and
// compared when DONE fires. Define COL_CONF_PARITY_EN to also exercise parity.
module tb_col_conf_loader;
  import col_conf_loader_pkg::*;

  typedef struct packed {
    logic [31:0]  alu;
    logic [31:0]  sel_a;
    logic [31:0]  sel_b;
    logic [15:0]  se;
    logic [127:0] ca;
    logic [127:0] cb;
  } ctx_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         cfg_valid = 1'b0;
  logic         cfg_sof = 1'b0;
  logic [15:0]  cfg_data = '0;
  logic         commit = 1'b0;
  logic         abort = 1'b0;
  logic         cfg_ready;
  logic [31:0]  conf_alu;
  logic [31:0]  conf_sel_a;
  logic [31:0]  conf_sel_b;
  logic [15:0]  conf_se;
  logic [127:0] const_a;
  logic [127:0] const_b;
  logic         armed;
  logic         done;
  logic         cfg_err;
`ifdef COL_CONF_PARITY_EN
  logic         par_flip = 1'b0;
  logic         cfg_par;
  assign cfg_par = (^cfg_data) ^ par_flip;
`endif

  ctx_t        sb[$];
  ctx_t        cur_ctx;
  logic [15:0] frame [FRAME_LEN];
  int          checks = 0;
  int          failures = 0;
  int          acc_cnt = 0;
  int          done_cnt = 0;
  int          n_push = 0;
  int          a0;

  col_conf_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_sof    (cfg_sof),
    .cfg_data   (cfg_data),
`ifdef COL_CONF_PARITY_EN
    .cfg_par    (cfg_par),
`endif
    .commit     (commit),
    .abort      (abort),
    .conf_alu   (conf_alu),
    .conf_sel_a (conf_sel_a),
    .conf_sel_b (conf_sel_b),
    .conf_se    (conf_se),
    .const_a    (const_a),
    .const_b    (const_b),
    .armed      (armed),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic checkCtx(input string tag, input ctx_t e);
    checkOutput({tag, "_alu"},   conf_alu,   e.alu);
    checkOutput({tag, "_sel_a"}, conf_sel_a, e.sel_a);
    checkOutput({tag, "_sel_b"}, conf_sel_b, e.sel_b);
    checkOutput({tag, "_se"},    conf_se,    e.se);
    checkOutput({tag, "_ca"},    const_a,    e.ca);
    checkOutput({tag, "_cb"},    const_b,    e.cb);
  endtask

  // Expected context from the frame as the column should decode it.
  function automatic ctx_t ctxOf();
    ctx_t c;
    logic [15:0] w;
    c = '0;
    for (int i = 0; i < PE_NUM; i++) begin
      w = frame[3*i];
      c.alu[i*4 +: 4]   = w[3:0];
      c.sel_a[i*4 +: 4] = w[7:4];
      c.sel_b[i*4 +: 4] = w[11:8];
      c.se[i*2 +: 2]    = w[13:12];
      c.ca[i*16 +: 16]  = frame[3*i+1];
      c.cb[i*16 +: 16]  = frame[3*i+2];
    end
    return c;
  endfunction

  task automatic fillFrameA();
    for (int i = 0; i < PE_NUM; i++) begin
      frame[3*i]   = 16'(i*16 + 1);
      frame[3*i+1] = 16'(16'h100 + i);
      frame[3*i+2] = 16'(16'h200 + i);
    end
  endtask

  task automatic fillRandom();
    for (int k = 0; k < FRAME_LEN; k++) frame[k] = 16'($urandom);
  endtask

  // Drive one word and hold it until the loader has taken it.
  task automatic sendWord(input int idx, input logic sof);
    logic rdy;
    logic ok;
    ok = 1'b0;
    cfg_valid = 1'b1;
    cfg_sof   = sof;
    cfg_data  = frame[idx];
    for (int n = 0; n < 50 && !ok; n++) begin
      rdy = cfg_ready;
      @(posedge clk);
      #1;
      if (rdy) ok = 1'b1;
    end
    if (!ok) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic applyStimulus(input int first, input int last, input bit gaps);
    for (int k = first; k <= last; k++) begin
      sendWord(k, k == 0);
      if (gaps && k[0]) begin
        cfg_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    cfg_valid = 1'b0;
    cfg_sof   = 1'b0;
  endtask

  task automatic pulseCtl(input bit c, input bit a);
    commit = c;
    abort  = a;
    @(posedge clk);
    #1;
    commit = 1'b0;
    abort  = 1'b0;
  endtask

  always @(posedge clk) begin
    if (rst_n && cfg_valid && cfg_ready) acc_cnt++;
  end

  always @(negedge clk) begin : done_mon
    ctx_t e;
    if (rst_n && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        checkCtx("commit", e);
        cur_ctx = e;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cur_ctx = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkCtx("reset", cur_ctx);
    checkOutput("reset_ready", cfg_ready, 0);
    checkOutput("reset_armed", armed, 0);
    checkOutput("reset_err", cfg_err, 0);
    rst_n = 1'b1;
    checkOutput("ready_release", cfg_ready, 0);
    @(posedge clk);
    #1;
    checkOutput("ready_after_release", cfg_ready, 1);

    $display("[TB] full frame with gaps and backpressure");
    fillFrameA();
    a0 = acc_cnt;
    applyStimulus(0, FRAME_LEN-1, 1'b1);
    cfg_valid = 1'b1;
    cfg_data  = 16'hBEEF;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk);
      #1;
      checkOutput("ready_armed", cfg_ready, 0);
    end
    cfg_valid = 1'b0;
    checkOutput("accepted_24", acc_cnt - a0, 24);
    checkOutput("armed_set", armed, 1);
    checkCtx("pre_commit", cur_ctx);
    sb.push_back(ctxOf());
    n_push++;
    pulseCtl(1'b1, 1'b0);
    checkOutput("done_pulse", done, 1);
    checkOutput("alu_pe0", conf_alu[3:0], 4'h1);
    checkOutput("constb_pe7", const_b[127:112], 16'h0207);
    checkOutput("armed_clear", armed, 0);
    @(posedge clk);
    #1;
    checkOutput("done_once", done, 0);

    $display("[TB] SOF mid-frame restart");
    fillRandom();
    applyStimulus(0, 9, 1'b0);
    fillRandom();
    applyStimulus(0, FRAME_LEN-1, 1'b0);
    checkOutput("err_restart", cfg_err, 1);
    checkOutput("armed_restart", armed, 1);
    sb.push_back(ctxOf());
    n_push++;
    pulseCtl(1'b1, 1'b0);
    checkOutput("done_restart", done, 1);
    @(posedge clk);
    #1;
    checkOutput("err_sticky", cfg_err, 1);

    $display("[TB] abort mid-frame");
    fillRandom();
    applyStimulus(0, 4, 1'b0);
    checkOutput("err_cleared_by_sof", cfg_err, 0);
    pulseCtl(1'b0, 1'b1);
    pulseCtl(1'b1, 1'b0);
    checkOutput("abort_no_done", done, 0);
    checkOutput("abort_ready", cfg_ready, 1);
    checkOutput("abort_armed", armed, 0);
    checkCtx("abort_keep", cur_ctx);
    sendWord(1, 1'b0);
    cfg_valid = 1'b0;
    checkOutput("idle_nonsof_err", cfg_err, 1);

    $display("[TB] commit and abort together");
    fillRandom();
    applyStimulus(0, FRAME_LEN-1, 1'b0);
    checkOutput("armed_ca", armed, 1);
    pulseCtl(1'b1, 1'b1);
    checkOutput("ca_no_done", done, 0);
    checkOutput("ca_armed", armed, 0);
    checkOutput("ca_ready", cfg_ready, 1);
    checkCtx("ca_keep", cur_ctx);
    pulseCtl(1'b1, 1'b0);
    checkOutput("idle_commit_ignored", done, 0);

`ifdef COL_CONF_PARITY_EN
    $display("[TB] parity error on word 7");
    fillRandom();
    applyStimulus(0, 6, 1'b0);
    par_flip = 1'b1;
    sendWord(7, 1'b0);
    par_flip = 1'b0;
    cfg_valid = 1'b0;
    checkOutput("par_err", cfg_err, 1);
    checkOutput("par_armed", armed, 0);
    checkCtx("par_keep", cur_ctx);
    sendWord(0, 1'b1);
    cfg_valid = 1'b0;
    checkOutput("par_back_to_idle", cfg_err, 0);
    pulseCtl(1'b0, 1'b1);
`endif

    $display("[TB] async reset mid-frame");
    fillRandom();
    applyStimulus(0, 5, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    cur_ctx = '0;
    checkCtx("async_reset", cur_ctx);
    checkOutput("async_reset_ready", cfg_ready, 0);
    checkOutput("async_reset_armed", armed, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("rst2_ready_release", cfg_ready, 0);
    @(posedge clk);
    #1;
    checkOutput("rst2_ready_after", cfg_ready, 1);
    pulseCtl(1'b1, 1'b0);
    checkOutput("rst2_no_done", done, 0);

    $display("[TB] frame after reset");
    fillFrameA();
    applyStimulus(0, FRAME_LEN-1, 1'b0);
    sb.push_back(ctxOf());
    n_push++;
    pulseCtl(1'b1, 1'b0);
    checkOutput("final_done", done, 1);
    @(posedge clk);
    #1;

    checkOutput("sb_drained", sb.size(), 0);
    checkOutput("done_count", done_cnt, n_push);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
